// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control unit: opcodes, FSM states,
// instruction classes and the datapath mux/ALU select codes.
package cpu_ctrl_pkg;

  localparam logic [6:0] OPC_ARITH_R = 7'b0110011;
  localparam logic [6:0] OPC_ARITH_I = 7'b0010011;
  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;

  typedef enum logic [2:0] {
    ST_IF    = 3'd0,
    ST_ID    = 3'd1,
    ST_EX    = 3'd2,
    ST_EX_BR = 3'd3,
    ST_MEM   = 3'd4,
    ST_WB    = 3'd5,
    ST_PC4   = 3'd6,
    ST_HALT  = 3'd7
  } state_t;

  typedef enum logic [3:0] {
    CLS_ARITH_R = 4'd0,
    CLS_ARITH_I = 4'd1,
    CLS_LOAD    = 4'd2,
    CLS_STORE   = 4'd3,
    CLS_BRANCH  = 4'd4,
    CLS_JAL     = 4'd5,
    CLS_JALR    = 4'd6,
    CLS_ECALL   = 4'd7,
    CLS_ILLEGAL = 4'd8
  } inst_class_t;

  localparam logic [1:0] ALU_OP_ADD   = 2'd0;
  localparam logic [1:0] ALU_OP_BR    = 2'd1;
  localparam logic [1:0] ALU_OP_FUNCT = 2'd2;

  localparam logic [1:0] ALU_SRC_B_RS2  = 2'd0;
  localparam logic [1:0] ALU_SRC_B_IMM  = 2'd1;
  localparam logic [1:0] ALU_SRC_B_FOUR = 2'd2;

  localparam logic ALU_SRC_A_PC  = 1'b0;
  localparam logic ALU_SRC_A_RS1 = 1'b1;

  localparam logic PC_SRC_PC4    = 1'b0;
  localparam logic PC_SRC_ALUOUT = 1'b1;

  function automatic logic is_jump(input inst_class_t cls);
    return (cls == CLS_JAL) || (cls == CLS_JALR);
  endfunction

endpackage

// File: rtl/control_opcode_decode.sv
// Combinational map from the 7-bit RV32I major opcode to an instruction class.
module control_opcode_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [6:0]  opcode,
  output inst_class_t cls
);

  always_comb begin
    cls = CLS_ILLEGAL;
    case (opcode)
      OPC_ARITH_R: cls = CLS_ARITH_R;
      OPC_ARITH_I: cls = CLS_ARITH_I;
      OPC_LOAD:    cls = CLS_LOAD;
      OPC_STORE:   cls = CLS_STORE;
      OPC_BRANCH:  cls = CLS_BRANCH;
      OPC_JAL:     cls = CLS_JAL;
      OPC_JALR:    cls = CLS_JALR;
      OPC_SYSTEM:  cls = CLS_ECALL;
      default:     cls = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I control FSM: sequences IF/ID/EX/MEM/WB and drives the
// datapath strobes and mux selects; halts on ECALL exit or illegal opcode.
module multicycle_control_fsm
  import cpu_ctrl_pkg::*;
#(
  parameter bit ECALL_HALT_EN = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       alu_bcond,
  input  logic       mem_ready,
  input  logic       is_halted,
  output logic       mem_read,
  output logic       mem_write,
  output logic       i_or_d,
  output logic       ir_write,
  output logic       reg_write,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       pc_write,
  output logic       pc_source,
  output logic       is_ecall,
  output logic       is_halted_out,
  output logic       illegal_inst,
  output logic       instr_retired
);

  state_t      state_q, state_d;
  inst_class_t cls_d, cls_q;
  logic        illegal_q;
  logic        halt_retire_q;
  logic        ecall_halts;

  control_opcode_decode u_decode (
    .opcode (opcode),
    .cls    (cls_d)
  );

  assign ecall_halts = is_halted && ECALL_HALT_EN;

  // Class is captured in ID so later states do not depend on IR staying put.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IF;
      cls_q         <= CLS_ILLEGAL;
      illegal_q     <= 1'b0;
      halt_retire_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      halt_retire_q <= (state_q == ST_ID) && (cls_d == CLS_ECALL) && ecall_halts;
      if (state_q == ST_ID) begin
        cls_q <= cls_d;
        if (cls_d == CLS_ILLEGAL) illegal_q <= 1'b1;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    i_or_d        = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    mem_to_reg    = 1'b0;
    alu_src_a     = ALU_SRC_A_PC;
    alu_src_b     = ALU_SRC_B_RS2;
    alu_op        = ALU_OP_ADD;
    pc_write      = 1'b0;
    pc_source     = PC_SRC_PC4;
    is_ecall      = 1'b0;
    is_halted_out = 1'b0;
    illegal_inst  = illegal_q;
    instr_retired = 1'b0;

    case (state_q)
      ST_IF: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          state_d  = ST_ID;
        end
      end

      ST_ID: begin
        alu_src_a = ALU_SRC_A_PC;
        alu_src_b = ALU_SRC_B_IMM;
        alu_op    = ALU_OP_ADD;
        case (cls_d)
          CLS_ARITH_R, CLS_ARITH_I, CLS_LOAD, CLS_STORE, CLS_JAL, CLS_JALR:
            state_d = ST_EX;
          CLS_BRANCH:
            state_d = ST_EX_BR;
          CLS_ECALL: begin
            is_ecall = 1'b1;
            state_d  = ecall_halts ? ST_HALT : ST_PC4;
          end
          default: begin
            illegal_inst = 1'b1;
            state_d      = ST_HALT;
          end
        endcase
      end

      ST_EX: begin
        case (cls_q)
          CLS_ARITH_R: begin
            alu_src_a = ALU_SRC_A_RS1;
            alu_src_b = ALU_SRC_B_RS2;
            alu_op    = ALU_OP_FUNCT;
            state_d   = ST_WB;
          end
          CLS_ARITH_I: begin
            alu_src_a = ALU_SRC_A_RS1;
            alu_src_b = ALU_SRC_B_IMM;
            alu_op    = ALU_OP_FUNCT;
            state_d   = ST_WB;
          end
          CLS_LOAD, CLS_STORE: begin
            alu_src_a = ALU_SRC_A_RS1;
            alu_src_b = ALU_SRC_B_IMM;
            state_d   = ST_MEM;
          end
          CLS_JALR: begin
            alu_src_a = ALU_SRC_A_RS1;
            alu_src_b = ALU_SRC_B_IMM;
            state_d   = ST_WB;
          end
          default: state_d = ST_WB;  // JAL: ALUOut already holds PC+imm
        endcase
      end

      ST_EX_BR: begin
        pc_write      = 1'b1;
        pc_source     = alu_bcond;
        instr_retired = 1'b1;
        state_d       = ST_IF;
        // Not taken: the ALU result feeds the PC, so it must be an add of PC+4.
        if (alu_bcond) begin
          alu_src_a = ALU_SRC_A_RS1;
          alu_src_b = ALU_SRC_B_RS2;
          alu_op    = ALU_OP_BR;
        end else begin
          alu_src_a = ALU_SRC_A_PC;
          alu_src_b = ALU_SRC_B_FOUR;
          alu_op    = ALU_OP_ADD;
        end
      end

      ST_MEM: begin
        i_or_d = 1'b1;
        if (cls_q == CLS_LOAD) begin
          mem_read = 1'b1;
          if (mem_ready) state_d = ST_WB;
        end else begin
          mem_write = 1'b1;
          if (mem_ready) begin
            alu_src_a     = ALU_SRC_A_PC;
            alu_src_b     = ALU_SRC_B_FOUR;
            pc_write      = 1'b1;
            pc_source     = PC_SRC_PC4;
            instr_retired = 1'b1;
            state_d       = ST_IF;
          end
        end
      end

      ST_WB: begin
        reg_write     = 1'b1;
        mem_to_reg    = (cls_q == CLS_LOAD);
        alu_src_a     = ALU_SRC_A_PC;
        alu_src_b     = ALU_SRC_B_FOUR;
        pc_write      = 1'b1;
        pc_source     = is_jump(cls_q) ? PC_SRC_ALUOUT : PC_SRC_PC4;
        instr_retired = 1'b1;
        state_d       = ST_IF;
      end

      ST_PC4: begin
        alu_src_a     = ALU_SRC_A_PC;
        alu_src_b     = ALU_SRC_B_FOUR;
        pc_write      = 1'b1;
        pc_source     = PC_SRC_PC4;
        instr_retired = 1'b1;
        state_d       = ST_IF;
      end

      ST_HALT: begin
        is_halted_out = 1'b1;
        instr_retired = halt_retire_q;
      end

      default: state_d = ST_IF;
    endcase

    if (reset) begin
      state_d       = ST_IF;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      i_or_d        = 1'b0;
      ir_write      = 1'b0;
      reg_write     = 1'b0;
      mem_to_reg    = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = '0;
      alu_op        = '0;
      pc_write      = 1'b0;
      pc_source     = 1'b0;
      is_ecall      = 1'b0;
      is_halted_out = 1'b0;
      illegal_inst  = 1'b0;
      instr_retired = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: per-cycle output vectors are
// compared against hand-derived constants for each instruction class.
module tb_multicycle_control_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] opcode;
  logic       alu_bcond;
  logic       mem_ready;
  logic       is_halted;
  logic       mem_read, mem_write, i_or_d, ir_write, reg_write, mem_to_reg;
  logic       alu_src_a;
  logic [1:0] alu_src_b, alu_op;
  logic       pc_write, pc_source, is_ecall, is_halted_out, illegal_inst, instr_retired;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  multicycle_control_fsm #(.ECALL_HALT_EN(1'b1)) dut (
    .clk           (clk),
    .reset         (reset),
    .opcode        (opcode),
    .alu_bcond     (alu_bcond),
    .mem_ready     (mem_ready),
    .is_halted     (is_halted),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .i_or_d        (i_or_d),
    .ir_write      (ir_write),
    .reg_write     (reg_write),
    .mem_to_reg    (mem_to_reg),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .pc_write      (pc_write),
    .pc_source     (pc_source),
    .is_ecall      (is_ecall),
    .is_halted_out (is_halted_out),
    .illegal_inst  (illegal_inst),
    .instr_retired (instr_retired)
  );

  // Bit order: mr mw iod irw rw m2r a b[1:0] op[1:0] pw ps ec ho il ret
  logic [16:0] obs;
  assign obs = {mem_read, mem_write, i_or_d, ir_write, reg_write, mem_to_reg, alu_src_a,
                alu_src_b, alu_op, pc_write, pc_source, is_ecall, is_halted_out,
                illegal_inst, instr_retired};

  localparam logic [16:0] V_ZERO        = 17'b0_0_0_0_0_0_0_00_00_0_0_0_0_0_0;
  localparam logic [16:0] V_IF_WAIT     = 17'b1_0_0_0_0_0_0_00_00_0_0_0_0_0_0;
  localparam logic [16:0] V_IF_GO       = 17'b1_0_0_1_0_0_0_00_00_0_0_0_0_0_0;
  localparam logic [16:0] V_ID          = 17'b0_0_0_0_0_0_0_01_00_0_0_0_0_0_0;
  localparam logic [16:0] V_EX_R        = 17'b0_0_0_0_0_0_1_00_10_0_0_0_0_0_0;
  localparam logic [16:0] V_EX_I        = 17'b0_0_0_0_0_0_1_01_10_0_0_0_0_0_0;
  localparam logic [16:0] V_EX_AGU      = 17'b0_0_0_0_0_0_1_01_00_0_0_0_0_0_0;
  localparam logic [16:0] V_WB_ARITH    = 17'b0_0_0_0_1_0_0_10_00_1_0_0_0_0_1;
  localparam logic [16:0] V_WB_LOAD     = 17'b0_0_0_0_1_1_0_10_00_1_0_0_0_0_1;
  localparam logic [16:0] V_WB_JUMP     = 17'b0_0_0_0_1_0_0_10_00_1_1_0_0_0_1;
  localparam logic [16:0] V_BR_T        = 17'b0_0_0_0_0_0_1_00_01_1_1_0_0_0_1;
  localparam logic [16:0] V_BR_NT       = 17'b0_0_0_0_0_0_0_10_00_1_0_0_0_0_1;
  localparam logic [16:0] V_MEM_LD      = 17'b1_0_1_0_0_0_0_00_00_0_0_0_0_0_0;
  localparam logic [16:0] V_MEM_ST      = 17'b0_1_1_0_0_0_0_00_00_0_0_0_0_0_0;
  localparam logic [16:0] V_MEM_ST_DONE = 17'b0_1_1_0_0_0_0_10_00_1_0_0_0_0_1;
  localparam logic [16:0] V_ECALL_ID    = 17'b0_0_0_0_0_0_0_01_00_0_0_1_0_0_0;
  localparam logic [16:0] V_PC4         = 17'b0_0_0_0_0_0_0_10_00_1_0_0_0_0_1;
  localparam logic [16:0] V_HALT_RET    = 17'b0_0_0_0_0_0_0_00_00_0_0_0_1_0_1;
  localparam logic [16:0] V_HALT        = 17'b0_0_0_0_0_0_0_00_00_0_0_0_1_0_0;
  localparam logic [16:0] V_ILL_ID      = 17'b0_0_0_0_0_0_0_01_00_0_0_0_0_1_0;
  localparam logic [16:0] V_HALT_ILL    = 17'b0_0_0_0_0_0_0_00_00_0_0_0_1_1_0;

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; mem_ready = 1'b1; opcode = 7'b0110011; alu_bcond = 1'b0; is_halted = 1'b0;
    next_cycle(); next_cycle(); #1;
    total++; if (obs !== V_ZERO) $display("FAIL reset_outputs: got %b exp %b", obs, V_ZERO); else passed++;
    reset = 1'b0; #1;
    total++; if (obs !== V_IF_GO) $display("FAIL reset_release_if: got %b exp %b", obs, V_IF_GO); else passed++;
  endtask

  task automatic test_arith;
    opcode = 7'b0110011; mem_ready = 1'b1; #1;
    total++; if (obs !== V_IF_GO) $display("FAIL add_if: got %b exp %b", obs, V_IF_GO); else passed++;
    next_cycle(); #1;
    total++; if (obs !== V_ID) $display("FAIL add_id: got %b exp %b", obs, V_ID); else passed++;
    next_cycle(); #1;
    total++; if (obs !== V_EX_R) $display("FAIL add_ex: got %b exp %b", obs, V_EX_R); else passed++;
    next_cycle(); #1;
    total++; if (obs !== V_WB_ARITH) $display("FAIL add_wb: got %b exp %b", obs, V_WB_ARITH); else passed++;
    next_cycle();
    opcode = 7'b0010011; #1;
    total++; if (obs !== V_IF_GO) $display("FAIL addi_if: got %b exp %b", obs, V_IF_GO); else passed++;
    next_cycle(); next_cycle(); #1;
    total++; if (obs !== V_EX_I) $display("FAIL addi_ex: got %b exp %b", obs, V_EX_I); else passed++;
    next_cycle(); #1;
    total++; if (obs !== V_WB_ARITH) $display("FAIL addi_wb: got %b exp %b", obs, V_WB_ARITH); else passed++;
    next_cycle();
  endtask

  task automatic test_load_wait;
    opcode = 7'b0000011; mem_ready = 1'b1; #1;
    total++; if (obs !== V_IF_GO) $display("FAIL lw_if: got %b exp %b", obs, V_IF_GO); else passed++;
    next_cycle(); mem_ready = 1'b0; #1;
    total++; if (obs !== V_ID) $display("FAIL lw_id: got %b exp %b", obs, V_ID); else passed++;
    next_cycle(); #1;
    total++; if (obs !== V_EX_AGU) $display("FAIL lw_ex: got %b exp %b", obs, V_EX_AGU); else passed++;
    next_cycle();
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (obs !== V_MEM_LD) $display("FAIL lw_mem_wait%0d: got %b exp %b", i, obs, V_MEM_LD); else passed++;
      next_cycle();
    end
    mem_ready = 1'b1; #1;
    total++; if (obs !== V_MEM_LD) $display("FAIL lw_mem_ready: got %b exp %b", obs, V_MEM_LD); else passed++;
    next_cycle(); #1;
    total++; if (obs !== V_WB_LOAD) $display("FAIL lw_wb: got %b exp %b", obs, V_WB_LOAD); else passed++;
    next_cycle();
  endtask

  task automatic test_branch;
    opcode = 7'b1100011; mem_ready = 1'b1; alu_bcond = 1'b1; #1;
    total++; if (obs !== V_IF_GO) $display("FAIL beq_t_if: got %b exp %b", obs, V_IF_GO); else passed++;
    next_cycle(); #1;
    total++; if (obs !== V_ID) $display("FAIL beq_t_id: got %b exp %b", obs, V_ID); else passed++;
    next_cycle(); #1;
    total++; if (obs !== V_BR_T) $display("FAIL beq_taken: got %b exp %b", obs, V_BR_T); else passed++;
    next_cycle(); alu_bcond = 1'b0; #1;
    total++; if (obs !== V_IF_GO) $display("FAIL beq_nt_if: got %b exp %b", obs, V_IF_GO); else passed++;
    next_cycle(); next_cycle(); #1;
    total++; if (obs !== V_BR_NT) $display("FAIL beq_not_taken: got %b exp %b", obs, V_BR_NT); else passed++;
    next_cycle();
  endtask

  task automatic test_store;
    opcode = 7'b0100011; mem_ready = 1'b1; #1;
    total++; if (obs !== V_IF_GO) $display("FAIL sw_if: got %b exp %b", obs, V_IF_GO); else passed++;
    next_cycle(); next_cycle(); #1;
    total++; if (obs !== V_EX_AGU) $display("FAIL sw_ex: got %b exp %b", obs, V_EX_AGU); else passed++;
    next_cycle(); #1;
    total++; if (obs !== V_MEM_ST_DONE) $display("FAIL sw_mem: got %b exp %b", obs, V_MEM_ST_DONE); else passed++;
    next_cycle(); #1;
    total++; if (obs !== V_IF_GO) $display("FAIL sw_back_to_if: got %b exp %b", obs, V_IF_GO); else passed++;
  endtask

  task automatic test_jumps;
    opcode = 7'b1101111; mem_ready = 1'b1;
    next_cycle(); next_cycle(); #1;
    total++; if (obs !== V_ZERO) $display("FAIL jal_ex: got %b exp %b", obs, V_ZERO); else passed++;
    next_cycle(); #1;
    total++; if (obs !== V_WB_JUMP) $display("FAIL jal_wb: got %b exp %b", obs, V_WB_JUMP); else passed++;
    next_cycle(); opcode = 7'b1100111;
    next_cycle(); next_cycle(); #1;
    total++; if (obs !== V_EX_AGU) $display("FAIL jalr_ex: got %b exp %b", obs, V_EX_AGU); else passed++;
    next_cycle(); #1;
    total++; if (obs !== V_WB_JUMP) $display("FAIL jalr_wb: got %b exp %b", obs, V_WB_JUMP); else passed++;
    next_cycle();
  endtask

  task automatic test_ecall;
    opcode = 7'b1110011; mem_ready = 1'b1; is_halted = 1'b0;
    next_cycle(); #1;
    total++; if (obs !== V_ECALL_ID) $display("FAIL ecall_nh_id: got %b exp %b", obs, V_ECALL_ID); else passed++;
    next_cycle(); #1;
    total++; if (obs !== V_PC4) $display("FAIL ecall_pc4: got %b exp %b", obs, V_PC4); else passed++;
    next_cycle(); #1;
    total++; if (obs !== V_IF_GO) $display("FAIL ecall_continue_if: got %b exp %b", obs, V_IF_GO); else passed++;
    next_cycle(); is_halted = 1'b1; #1;
    total++; if (obs !== V_ECALL_ID) $display("FAIL ecall_h_id: got %b exp %b", obs, V_ECALL_ID); else passed++;
    next_cycle(); #1;
    total++; if (obs !== V_HALT_RET) $display("FAIL halt_entry: got %b exp %b", obs, V_HALT_RET); else passed++;
    for (int i = 0; i < 20; i++) begin
      next_cycle(); mem_ready = i[0]; is_halted = i[1]; #1;
      total++; if (obs !== V_HALT) $display("FAIL halt_hold%0d: got %b exp %b", i, obs, V_HALT); else passed++;
    end
    reset = 1'b1; is_halted = 1'b0; mem_ready = 1'b1; #1;
    total++; if (obs !== V_ZERO) $display("FAIL halt_reset: got %b exp %b", obs, V_ZERO); else passed++;
    next_cycle(); reset = 1'b0; opcode = 7'b0110011; #1;
    total++; if (obs !== V_IF_GO) $display("FAIL halt_reset_if: got %b exp %b", obs, V_IF_GO); else passed++;
  endtask

  task automatic test_illegal;
    opcode = 7'b0000000; mem_ready = 1'b1;
    next_cycle(); #1;
    total++; if (obs !== V_ILL_ID) $display("FAIL illegal_id: got %b exp %b", obs, V_ILL_ID); else passed++;
    next_cycle(); #1;
    total++; if (obs !== V_HALT_ILL) $display("FAIL illegal_halt: got %b exp %b", obs, V_HALT_ILL); else passed++;
    next_cycle(); #1;
    total++; if (obs !== V_HALT_ILL) $display("FAIL illegal_sticky: got %b exp %b", obs, V_HALT_ILL); else passed++;
    reset = 1'b1; #1;
    total++; if (obs !== V_ZERO) $display("FAIL illegal_reset: got %b exp %b", obs, V_ZERO); else passed++;
    next_cycle(); reset = 1'b0; mem_ready = 1'b0; #1;
    total++; if (obs !== V_IF_WAIT) $display("FAIL illegal_cleared_if: got %b exp %b", obs, V_IF_WAIT); else passed++;
    next_cycle(); #1;
    total++; if (obs !== V_IF_WAIT) $display("FAIL if_stall: got %b exp %b", obs, V_IF_WAIT); else passed++;
  endtask

  task automatic test_store_reset;
    opcode = 7'b0100011; mem_ready = 1'b1; #1;
    total++; if (obs !== V_IF_GO) $display("FAIL swr_if: got %b exp %b", obs, V_IF_GO); else passed++;
    next_cycle(); next_cycle(); mem_ready = 1'b0; next_cycle(); #1;
    total++; if (obs !== V_MEM_ST) $display("FAIL swr_mem_wait0: got %b exp %b", obs, V_MEM_ST); else passed++;
    next_cycle(); #1;
    total++; if (obs !== V_MEM_ST) $display("FAIL swr_mem_wait1: got %b exp %b", obs, V_MEM_ST); else passed++;
    reset = 1'b1; mem_ready = 1'b1; #1;
    total++; if (obs !== V_ZERO) $display("FAIL swr_reset_cycle: got %b exp %b", obs, V_ZERO); else passed++;
    next_cycle(); reset = 1'b0; opcode = 7'b0110011; #1;
    total++; if (obs !== V_IF_GO) $display("FAIL swr_restart_if: got %b exp %b", obs, V_IF_GO); else passed++;
    next_cycle(); #1;
    total++; if (obs !== V_ID) $display("FAIL swr_restart_id: got %b exp %b", obs, V_ID); else passed++;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got %0d passed exp %0d", passed, total);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_arith();
    test_load_wait();
    test_branch();
    test_store();
    test_jumps();
    test_ecall();
    test_illegal();
    test_store_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Multi-cycle RV32I control unit. Sequences IF/ID/EX/MEM/WB per instruction.
- Drives the register file's write_enable and is_ecall, plus memory, IR, PC and ALU mux selects.
- Consumes the register file's is_halted to stop the machine on ECALL with x17==10.
- Memory handshake is variable-latency via mem_ready.

Parameters:
- ECALL_HALT_EN, 1, when 1 a halting ECALL enters HALT; when 0 ECALL retires as a NOP.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high reset
- opcode  input  7  IR[6:0] of the latched instruction
- alu_bcond  input  1  branch-condition result from ALU, valid in EX
- mem_ready  input  1  memory completed current access this cycle
- is_halted  input  1  from register file (combinational, valid while is_ecall=1)
- mem_read / mem_write  output  1  memory strobes, held until mem_ready
- i_or_d  output  1  0=PC addresses memory, 1=ALUOut
- ir_write  output  1  latch instruction into IR
- reg_write  output  1  register file write_enable
- mem_to_reg  output  1  rd source: 0=ALUOut, 1=MDR
- alu_src_a  output  1  0=PC, 1=rs1
- alu_src_b  output  2  0=rs2, 1=imm, 2=const 4
- alu_op  output  2  0=add, 1=branch compare, 2=funct-decoded
- pc_write  output  1  update PC this cycle
- pc_source  output  1  0=PC+4 (ALU result), 1=ALUOut (target)
- is_ecall  output  1  ECALL being decoded
- is_halted_out  output  1  sticky, machine stopped
- illegal_inst  output  1  sticky, unknown opcode seen
- instr_retired  output  1  one-cycle pulse per completed instruction

Behaviour:
- States:
  - IF: mem_read=1, i_or_d=0; on mem_ready ir_write=1 and go to ID, else stay.
  - ID: alu_src_a=0, alu_src_b=1, alu_op=0, so ALUOut<=PC+imm.
- Routing out of ID:
  - R/I-arith (0110011/0010011), load (0000011), store (0100011), JAL (1101111), JALR (1100111): go to EX.
  - Branch (1100011): go to EX_BR.
  - ECALL (1110011): is_ecall=1. If is_halted and ECALL_HALT_EN, go to HALT; else go to PC4.
  - Other opcode: set illegal_inst, go to HALT.
- EX, per class:
  - Arith: alu_src_a=1, alu_src_b=0 (R) or 1 (I), alu_op=2.
  - Load/store: alu_src_a=1, alu_src_b=1, alu_op=0.
  - JAL: ALUOut keeps PC+imm; no ALU capture.
  - JALR: rs1+imm.
- Exits from EX: arith goes to WB; load/store go to MEM; JAL/JALR go to WB.
- EX_BR: alu_src_a=1, alu_src_b=0, alu_op=1, pc_write=1, pc_source=alu_bcond. On alu_bcond=0 the ALU sees PC+4 via an internal reselect (alu_src_a=0, alu_src_b=2). instr_retired=1, go to IF.
- MEM: i_or_d=1; mem_read (load) or mem_write (store) held until mem_ready.
  - Load + mem_ready: go to WB.
  - Store + mem_ready: alu_src_a=0, alu_src_b=2, pc_write=1, pc_source=0, instr_retired=1, go to IF.
- WB: reg_write=1 (mem_to_reg=1 for load), ALU computes PC+4.
  - Arith/load: pc_write=1, pc_source=0.
  - JAL/JALR: rd gets PC+4; pc_write=1, pc_source=1 (ALUOut target).
  - instr_retired=1, go to IF.
- PC4: pc_write=1, pc_source=0, alu_src_a=0, alu_src_b=2, instr_retired=1, go to IF.
- HALT: absorbing. All strobes 0; is_halted_out=1 (the halting ECALL counts as retired once, pulsed on HALT entry). Leaves only on reset.
- Every write strobe (reg_write, mem_write, pc_write, ir_write) is at most one cycle per instruction, except mem_write, which is held while waiting.
- mem_ready outside IF/MEM is ignored.
- Reset: any state goes to IF next cycle; sticky flags cleared.
  - While reset=1, all outputs are forced 0 so no write collides with register-file reset.
  - Reset mid-MEM abandons the access; no partial retire.
- Latency with mem_ready tied high:
  - Arith 4 cycles, load 5, store 4, branch 3, JAL 4, non-halting ECALL 3.

Decomposition:
- Package cpu_ctrl_pkg holds:
  - Opcode constants.
  - State encoding (IF, ID, EX, EX_BR, MEM, WB, PC4, HALT; 3-bit).
  - ALU_OP_*, ALU_SRC_B_*, PC_SRC_* encodings.
- Sub-module control_opcode_decode: combinational opcode → instruction class (ARITH_R, ARITH_I, LOAD, STORE, BRANCH, JAL, JALR, ECALL, ILLEGAL).

Test Plan:
- Reset then ADD (0110011), mem_ready=1 → states IF,ID,EX,WB; reg_write=1 exactly at cycle 4; one instr_retired.
- LW with mem_ready low 3 cycles in MEM → mem_read,i_or_d=1 held 4 cycles; reg_write with mem_to_reg=1 one cycle after ready.
- BEQ with alu_bcond=1, then alu_bcond=0 → pc_write at cycle 3 with pc_source=1, then pc_source=0; reg_write never asserted.
- ECALL with is_halted=1 → is_ecall=1 in ID, HALT next cycle, is_halted_out=1 stays 1 for 20 cycles despite mem_ready toggling; is_halted=0 → PC4, execution continues.
- Opcode 0000000 → illegal_inst=1, HALT; then reset=1 for 1 cycle → outputs 0 during reset, IF with mem_read=1 after, flags cleared.
- SW, reset asserted mid-MEM wait → mem_write drops in reset cycle, no pc_write, no instr_retired.
